// File: rtl/fpga_channel_pkg.sv
// Shared types and helpers for the harness input channel.
// Provides the channel FSM state type and the pointer-width helper.
// No ports; imported by in_channel and in_channel_ram.
package fpga_channel_pkg;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        EMPTY = 2'd2
    } in_channel_state_t;

    localparam int DEFAULT_MEW = 12;
    localparam int DEFAULT_NIN = 2;

    // Pointers must be able to hold NIn itself (the "full" / "all read" value).
    function automatic int ptr_width(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    // Address width for an n-entry array; at least one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/in_channel_ram.sv
// Channel storage: DEPTH x W array, synchronous write, synchronous registered read.
// Latency: write visible next cycle; rd_data valid one cycle after rd_en.
// Ports: clock/reset, write port (wr_en/wr_addr/wr_data), read port (rd_en/rd_addr/rd_data).
module in_channel_ram
    import fpga_channel_pkg::*;
#(
    parameter int W     = DEFAULT_MEW,
    parameter int DEPTH = DEFAULT_NIN,
    parameter int AW    = addr_width(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Array contents survive reset; only the output register is cleared.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Output register holds its value when no read is issued.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/in_channel.sv
// Loadable, one-shot input channel for the program executor (FILL -> RUN -> EMPTY).
// Latency: load->stored 1 cycle, seal->sealed/inSize 1 cycle, pop->readData/readValid 1 cycle.
// Ports: producer side loadValid/loadData/loadReady/loadDone, executor side readReq/readData/
// readValid/inSize, status sealed/underflow. loadReady drops when full or once sealed.
module in_channel
    import fpga_channel_pkg::*;
#(
    parameter int MemoryElementWidth = DEFAULT_MEW,
    parameter int NIn                = DEFAULT_NIN
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          loadValid,
    input  logic [MemoryElementWidth-1:0] loadData,
    output logic                          loadReady,
    input  logic                          loadDone,
    output logic                          sealed,
    input  logic                          readReq,
    output logic [MemoryElementWidth-1:0] readData,
    output logic                          readValid,
    output logic [MemoryElementWidth-1:0] inSize,
    output logic                          underflow
);

    localparam int MEW = MemoryElementWidth;
    localparam int PW  = ptr_width(NIn);
    localparam int RAW = addr_width(NIn);

    in_channel_state_t state;
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [PW-1:0]     wp_nxt;
    logic              accept;
    logic              pop;

    // loadReady is only ever high in FILL, so it alone qualifies a load.
    assign accept = loadValid && loadReady;
    assign pop    = (state == RUN) && readReq;
    assign wp_nxt = accept ? wp + PW'(1) : wp;

    in_channel_ram #(
        .W     (MEW),
        .DEPTH (NIn),
        .AW    (RAW)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (accept),
        .wr_addr (wp[RAW-1:0]),
        .wr_data (loadData),
        .rd_en   (pop),
        .rd_addr (rp[RAW-1:0]),
        .rd_data (readData)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= FILL;
            wp        <= '0;
            rp        <= '0;
            loadReady <= 1'b1;
            sealed    <= 1'b0;
            readValid <= 1'b0;
            inSize    <= '0;
            underflow <= 1'b0;
        end else begin
            readValid <= 1'b0;
            case (state)
                FILL: begin
                    wp <= wp_nxt;
                    // A word accepted in the sealing cycle is counted before sealing.
                    loadReady <= !loadDone && (wp_nxt < PW'(NIn));
                    if (loadDone) begin
                        sealed <= 1'b1;
                        inSize <= MEW'(wp_nxt);
                        state  <= (wp_nxt == '0) ? EMPTY : RUN;
                    end
                end
                RUN: begin
                    loadReady <= 1'b0;
                    if (readReq) begin
                        rp        <= rp + PW'(1);
                        inSize    <= inSize - MEW'(1);
                        readValid <= 1'b1;
                        // Last word leaves: go EMPTY in the same cycle inSize hits 0.
                        if (inSize == MEW'(1)) begin
                            state <= EMPTY;
                        end
                    end
                end
                EMPTY: begin
                    loadReady <= 1'b0;
                    if (readReq) begin
                        underflow <= 1'b1;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_in_channel.sv
module tb_in_channel;

    localparam int MEW = 12;
    localparam int NIN = 2;

    logic           clock = 1'b0;
    logic           reset;
    logic           loadValid;
    logic [MEW-1:0] loadData;
    logic           loadReady;
    logic           loadDone;
    logic           sealed;
    logic           readReq;
    logic [MEW-1:0] readData;
    logic           readValid;
    logic [MEW-1:0] inSize;
    logic           underflow;

    in_channel #(
        .MemoryElementWidth (MEW),
        .NIn                (NIN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .loadValid (loadValid),
        .loadData  (loadData),
        .loadReady (loadReady),
        .loadDone  (loadDone),
        .sealed    (sealed),
        .readReq   (readReq),
        .readData  (readData),
        .readValid (readValid),
        .inSize    (inSize),
        .underflow (underflow)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: the channel is a bounded queue that becomes read-only once sealed.
    int unsigned q[$];
    bit          m_sealed = 0;
    bit          m_under  = 0;
    bit          m_valid  = 0;
    int unsigned m_data   = 0;
    int unsigned m_size   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic lv, input logic [MEW-1:0] d,
                        input logic done, input logic rr);
        bit ready_before;
        reset     = rst;
        loadValid = lv;
        loadData  = d;
        loadDone  = done;
        readReq   = rr;
        ready_before = !m_sealed && (q.size() < NIN);
        @(posedge clock);
        if (rst) begin
            q.delete();
            m_sealed = 0; m_under = 0; m_valid = 0; m_data = 0; m_size = 0;
        end else begin
            m_valid = 0;
            if (!m_sealed) begin
                if (lv && ready_before) q.push_back(int'(d));
                if (done) begin
                    m_sealed = 1;
                    m_size   = q.size();
                end
            end else if (rr) begin
                if (q.size() > 0) begin
                    m_data  = q.pop_front();
                    m_valid = 1;
                    m_size  = q.size();
                end else begin
                    m_under = 1;
                end
            end
        end
        #1;
        chk("loadReady", 32'(loadReady), 32'(!m_sealed && (q.size() < NIN)));
        chk("sealed",    32'(sealed),    32'(m_sealed));
        chk("readValid", 32'(readValid), 32'(m_valid));
        chk("readData",  32'(readData),  m_data);
        chk("inSize",    32'(inSize),    m_size);
        chk("underflow", 32'(underflow), 32'(m_under));
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0);
    endtask

    task automatic load(input logic [MEW-1:0] d);
        step(0, 1, d, 0, 0);
    endtask

    task automatic seal();
        step(0, 0, '0, 1, 0);
    endtask

    task automatic pop();
        step(0, 0, '0, 0, 1);
    endtask

    task automatic do_reset();
        step(1, 0, '0, 0, 0);
    endtask

    initial begin
        reset = 1'b1; loadValid = 1'b0; loadData = '0; loadDone = 1'b0; readReq = 1'b0;

        // Reset state
        do_reset();
        do_reset();
        chk("rst_loadReady", 32'(loadReady), 32'd1);
        chk("rst_inSize",    32'(inSize),    32'd0);
        chk("rst_readData",  32'(readData),  32'd0);

        // 1: load 88, 44, seal, pop twice
        load(88);
        load(44);
        seal();
        chk("t1_sealed",    32'(sealed),    32'd1);
        chk("t1_inSize",    32'(inSize),    32'd2);
        chk("t1_loadReady", 32'(loadReady), 32'd0);
        pop();
        chk("t1_pop1_data", 32'(readData), 32'd88);
        chk("t1_pop1_size", 32'(inSize),   32'd1);
        pop();
        chk("t1_pop2_data", 32'(readData), 32'd44);
        chk("t1_pop2_size", 32'(inSize),   32'd0);

        // 2: pop while EMPTY; underflow sticky
        pop();
        chk("t2_valid", 32'(readValid), 32'd0);
        chk("t2_data",  32'(readData),  32'd44);
        chk("t2_under", 32'(underflow), 32'd1);
        idle();
        load(7);
        seal();
        chk("t2_sticky", 32'(underflow), 32'd1);

        // 3: three offers, capacity two
        do_reset();
        load(101);
        load(202);
        chk("t3_full_ready", 32'(loadReady), 32'd0);
        load(303);
        seal();
        chk("t3_inSize", 32'(inSize), 32'd2);
        pop();
        chk("t3_pop1", 32'(readData), 32'd101);
        pop();
        chk("t3_pop2", 32'(readData), 32'd202);
        pop();
        chk("t3_under", 32'(underflow), 32'd1);

        // 4: readReq in FILL is ignored; seal with zero words
        do_reset();
        pop();
        chk("t4_valid", 32'(readValid), 32'd0);
        chk("t4_under", 32'(underflow), 32'd0);
        chk("t4_ready", 32'(loadReady), 32'd1);
        seal();
        chk("t4_sealed", 32'(sealed), 32'd1);
        chk("t4_inSize", 32'(inSize), 32'd0);
        pop();
        chk("t4_under_empty", 32'(underflow), 32'd1);

        // 5: load and seal in the same cycle
        do_reset();
        load(5);
        step(0, 1, 12'd77, 1, 0);
        chk("t5_inSize", 32'(inSize), 32'd2);
        pop();
        chk("t5_pop1", 32'(readData), 32'd5);
        pop();
        chk("t5_pop2", 32'(readData), 32'd77);

        // 6: reset mid-RUN, then reuse
        do_reset();
        load(1);
        load(2);
        seal();
        pop();
        do_reset();
        chk("t6_sealed", 32'(sealed),    32'd0);
        chk("t6_inSize", 32'(inSize),    32'd0);
        chk("t6_under",  32'(underflow), 32'd0);
        chk("t6_ready",  32'(loadReady), 32'd1);
        load(9);
        seal();
        pop();
        chk("t6_pop", 32'(readData), 32'd9);

        // Randomized rounds against the queue model
        for (int r = 0; r < 40; r++) begin
            do_reset();
            for (int c = 0; c < 14; c++) begin
                step(0, 1'($urandom_range(0, 1)), MEW'($urandom),
                     1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
